multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the opcode held in the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback. It is the producer of the 2-bit ALUOp code consumed by the ALU control decoder, and drives every datapath mux and enable. Memory accesses use a MemReady handshake so that slow memories stall the FSM.

Parameters:
CNT_W, 16, width of the retired-instruction counter InstrCount.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  opcode, IR[31:26]
Funct  in  6  funct field, IR[5:0]
MemReady  in  1  memory access complete this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
IorD  out  1  0 = PC address, 1 = ALUOut address
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
State  out  4  current state, for debug
IllegalOp  out  1  registered one-cycle pulse on an unsupported opcode
InstrCount  out  CNT_W  count of retired instructions

Behaviour:
- Moore FSM with a 4-bit state register. All control outputs are combinational decodes of State only, except that PCWrite/IRWrite in FETCH are gated by MemReady. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 go to FETCH on the next clock.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and IRWrite=PCWrite=MemReady. Hold in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 with Funct!=0: EXEC.
  - 000000 with Funct=0 (nop): FETCH, no register write.
  - 000100 (beq): BRANCH.
  - 000010 (j): JUMP.
  - 001000 (addi): see Optional Feature.
  - Any other opcode: FETCH, with IllegalOp=1 for exactly the next cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if Op=lw, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until MemReady=1, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- Minimum cycles per instruction with MemReady held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, nop 2, illegal 2. Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- InstrCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB, or from DECODE on a nop. It does not increment on an illegal opcode. It wraps from all-ones to 0.
- reset, asynchronous at any time including mid-instruction:
  - State=FETCH, IllegalOp=0, InstrCount=0.
  - Outputs are the FETCH decode: MemRead=1, ALUSrcB=01, and IRWrite/PCWrite follow MemReady. All others are 0.
  - Memory strobes from the aborted state drop immediately.

Optional Feature:
MC_ADDI_EN.
- Defined: Op=001000 in DECODE goes to ADDIEX.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH; counts as retired.
- Undefined: 001000 is illegal (IllegalOp pulse, return to FETCH, no count). States 10 and 11 are treated as unused codes.

Test Plan:
- reset, then lw (Op=100011) with MemReady=1 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrCount=1.
- sw with MemReady low for 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 cycles; no RegWrite; back to FETCH; count +1.
- R-type Op=0, Funct=100000 -> ALUOp=10 in EXEC, then RegDst=1, RegWrite=1; nop (Op=0, Funct=0) -> 1,0 with no RegWrite; count +1.
- beq then j -> PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH; PCWrite=1, PCSource=10 in JUMP.
- Op=111111 -> IllegalOp high exactly one cycle; State returns to 0; InstrCount unchanged. Repeat with Op=001000 with and without MC_ADDI_EN.
- Assert reset during MEMRD with MemReady=0 -> State=0 and InstrCount=0 immediately; with CNT_W=4, retire 17 instructions -> InstrCount=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// multicycle_control_if : opcode/handshake inputs and datapath controls for
//                         the multicycle MIPS main control FSM
// Revision 1.0
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       State;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Funct, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           State, IllegalOp, InstrCount
  );

  modport slave (
    output Op, Funct, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           State, IllegalOp, InstrCount
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : Moore main-control FSM for the multicycle MIPS
//                      datapath. Define MC_ADDI_EN to support addi.
// Revision 1.0
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;

  // Next state; retire marks every transition that completes an instruction.
  always_comb begin
    state_d      = S_FETCH;
    retire       = 1'b0;
    illegal_op_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (bus.Funct != 6'd0) begin
              state_d = S_EXEC;
            end else begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI: state_d = S_ADDIEX;
`endif
          default: illegal_op_d = 1'b1;
        endcase
      end
      S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  retire  = 1'b1;
      S_MEMWR: begin
        if (bus.MemReady) begin
          retire = 1'b1;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    retire  = 1'b1;
      S_BRANCH: retire  = 1'b1;
      S_JUMP:   retire  = 1'b1;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: retire  = 1'b1;
`endif
      default:  state_d = S_FETCH;
    endcase
    instr_count_d = retire ? instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1}
                           : instr_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      illegal_op_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Control outputs decode the state register only (plus MemReady in FETCH).
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.State      = state_q;
  assign bus.IllegalOp  = illegal_op_q;
  assign bus.InstrCount = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : directed vector table plus hand-written sequences
// Revision 1.0
// ============================================================================
module tb_multicycle_control;
  localparam int W = 4;

  // Control word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  localparam logic [15:0] C_F0   = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_F1   = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_MRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] C_MWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_EXE  = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] C_RWB  = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] C_BR   = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_J    = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
`ifdef MC_ADDI_EN
  localparam logic [15:0] C_AWB  = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_if #(.CNT_W(W)) bus ();
  multicycle_control #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   op;
    logic [5:0]   funct;
    logic         mr;
    logic [3:0]   st;
    logic [15:0]  ctrl;
    logic         ill;
    logic [W-1:0] cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] cnt_now;

  logic [15:0] ctrl;
  assign ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                 bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                 bus.PCSource};

  task automatic add(input logic [5:0] op, input logic [5:0] funct,
                     input logic mr, input logic [3:0] st,
                     input logic [15:0] c, input logic ill,
                     input logic [W-1:0] cnt);
    vec_t v;
    v.op = op; v.funct = funct; v.mr = mr;
    v.st = st; v.ctrl = c; v.ill = ill; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st,
                       input logic [15:0] c, input logic ill,
                       input logic [W-1:0] cnt);
    checks++;
    if ({bus.State, ctrl, bus.IllegalOp, bus.InstrCount} !== {st, c, ill, cnt}) begin
      errors++;
      $display("FAIL %s: got state=%0d ctrl=%b ill=%b cnt=%0d, expected state=%0d ctrl=%b ill=%b cnt=%0d",
               name, bus.State, ctrl, bus.IllegalOp, bus.InstrCount, st, c, ill, cnt);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic mr);
    bus.Op       = op;
    bus.Funct    = funct;
    bus.MemReady = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Op = '0; bus.Funct = '0; bus.MemReady = 1'b0;
    reset = 1'b1;
    #12;
    check("reset_mr0", 4'd0, C_F0, 1'b0, 4'd0);
    bus.MemReady = 1'b1;
    #1;
    check("reset_mr1", 4'd0, C_F1, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // lw
    add(LW, 6'd0, 1'b1, 4'd1, C_DEC,  1'b0, 4'd0);
    add(LW, 6'd0, 1'b1, 4'd2, C_MADR, 1'b0, 4'd0);
    add(LW, 6'd0, 1'b1, 4'd3, C_MRD,  1'b0, 4'd0);
    add(LW, 6'd0, 1'b1, 4'd4, C_MWB,  1'b0, 4'd0);
    add(LW, 6'd0, 1'b1, 4'd0, C_F1,   1'b0, 4'd1);
    // sw with three wait cycles in MEMWR
    add(SW, 6'd0, 1'b1, 4'd1, C_DEC,  1'b0, 4'd1);
    add(SW, 6'd0, 1'b1, 4'd2, C_MADR, 1'b0, 4'd1);
    add(SW, 6'd0, 1'b1, 4'd5, C_MWR,  1'b0, 4'd1);
    add(SW, 6'd0, 1'b0, 4'd5, C_MWR,  1'b0, 4'd1);
    add(SW, 6'd0, 1'b0, 4'd5, C_MWR,  1'b0, 4'd1);
    add(SW, 6'd0, 1'b0, 4'd5, C_MWR,  1'b0, 4'd1);
    add(SW, 6'd0, 1'b1, 4'd0, C_F1,   1'b0, 4'd2);
    // R-type add
    add(6'd0, 6'b100000, 1'b1, 4'd1, C_DEC, 1'b0, 4'd2);
    add(6'd0, 6'b100000, 1'b1, 4'd6, C_EXE, 1'b0, 4'd2);
    add(6'd0, 6'b100000, 1'b1, 4'd7, C_RWB, 1'b0, 4'd2);
    add(6'd0, 6'b100000, 1'b1, 4'd0, C_F1,  1'b0, 4'd3);
    // nop
    add(6'd0, 6'd0, 1'b1, 4'd1, C_DEC, 1'b0, 4'd3);
    add(6'd0, 6'd0, 1'b1, 4'd0, C_F1,  1'b0, 4'd4);
    // beq, j
    add(BEQ, 6'd0, 1'b1, 4'd1, C_DEC, 1'b0, 4'd4);
    add(BEQ, 6'd0, 1'b1, 4'd8, C_BR,  1'b0, 4'd4);
    add(BEQ, 6'd0, 1'b1, 4'd0, C_F1,  1'b0, 4'd5);
    add(JMP, 6'd0, 1'b1, 4'd1, C_DEC, 1'b0, 4'd5);
    add(JMP, 6'd0, 1'b1, 4'd9, C_J,   1'b0, 4'd5);
    add(JMP, 6'd0, 1'b1, 4'd0, C_F1,  1'b0, 4'd6);
    // illegal opcode: one-cycle pulse, no count; then a FETCH stall
    add(BAD, 6'd0, 1'b1, 4'd1, C_DEC, 1'b0, 4'd6);
    add(BAD, 6'd0, 1'b1, 4'd0, C_F1,  1'b1, 4'd6);
    add(BAD, 6'd0, 1'b0, 4'd0, C_F0,  1'b0, 4'd6);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].op, vq[i].funct, vq[i].mr);
      check($sformatf("vec%0d", i), vq[i].st, vq[i].ctrl, vq[i].ill, vq[i].cnt);
    end

    // addi: executes with the feature, illegal without it
    step(ADDI, 6'd0, 1'b1);
    check("addi_decode", 4'd1, C_DEC, 1'b0, 4'd6);
`ifdef MC_ADDI_EN
    step(ADDI, 6'd0, 1'b1);
    check("addi_ex", 4'd10, C_MADR, 1'b0, 4'd6);
    step(ADDI, 6'd0, 1'b1);
    check("addi_wb", 4'd11, C_AWB, 1'b0, 4'd6);
    step(ADDI, 6'd0, 1'b1);
    check("addi_done", 4'd0, C_F1, 1'b0, 4'd7);
    cnt_now = 4'd7;
`else
    step(ADDI, 6'd0, 1'b1);
    check("addi_illegal", 4'd0, C_F1, 1'b1, 4'd6);
    step(ADDI, 6'd0, 1'b0);
    check("addi_pulse_end", 4'd0, C_F0, 1'b0, 4'd6);
    cnt_now = 4'd6;
`endif

    // Asynchronous reset while stalled in MEMRD
    step(LW, 6'd0, 1'b1);
    step(LW, 6'd0, 1'b1);
    step(LW, 6'd0, 1'b0);
    step(LW, 6'd0, 1'b0);
    check("memrd_stall", 4'd3, C_MRD, 1'b0, cnt_now);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 4'd0, C_F0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Counter wrap: 17 nops on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      step(6'd0, 6'd0, 1'b1);
      step(6'd0, 6'd0, 1'b1);
      if (i == 15) check("wrap_zero", 4'd0, C_F1, 1'b0, 4'd0);
    end
    check("wrap_one", 4'd0, C_F1, 1'b0, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
